// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the IF/ID hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef logic [1:0] state_t;

    localparam state_t      c_ST_RUN    = 2'd0;
    localparam state_t      c_ST_STALL  = 2'd1;
    localparam state_t      c_ST_FLUSH  = 2'd2;

    localparam logic [31:0] c_NOP       = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam int unsigned c_MAX_STALL = 2;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// ============================================================================
//  Module      : perf_counter
//  Description : Free-running wrapping event counter with synchronous
//                active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : IF/ID pipeline register with stall/flush control, stall
//                watchdog and optional performance counters
//                (enabled by defining HAZARD_PERF_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bb_data,
    input  logic        jump_taken_id,
    input  logic [31:0] pc_if,
    input  logic [31:0] instr_if,
    output logic        pc_write_en,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic        bubble_ex,
    output logic [1:0]  state_o,
    output logic        stall_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int          c_RUN_W   = $clog2(c_MAX_STALL + 2);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(c_MAX_STALL);

    logic [31:0]        r_pc_id;
    logic [31:0]        r_instr_id;
    logic               r_valid_id;
    state_t             r_state;
    state_t             w_state_next;
    logic [c_RUN_W-1:0] r_stall_run;
    logic               r_stall_err;
    logic               w_stall_q;
    logic               w_flush_enter;

    // A stall request against an empty slot is meaningless and is dropped.
    assign w_stall_q   = bb_data & r_valid_id;
    assign pc_write_en = ~w_stall_q;
    assign bubble_ex   = w_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_id    <= c_RESET_PC;
            r_instr_id <= c_NOP;
            r_valid_id <= 1'b0;
        end else if (!w_stall_q) begin
            r_pc_id <= pc_if;
            if (jump_taken_id) begin
                r_instr_id <= c_NOP;
                r_valid_id <= 1'b0;
            end else begin
                r_instr_id <= instr_if;
                r_valid_id <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = c_ST_RUN;
        case (r_state)
            c_ST_RUN: begin
                if (w_stall_q) begin
                    w_state_next = c_ST_STALL;
                end else if (jump_taken_id) begin
                    w_state_next = c_ST_FLUSH;
                end
            end
            c_ST_STALL: begin
                if (w_stall_q) begin
                    w_state_next = c_ST_STALL;
                end
            end
            c_ST_FLUSH: w_state_next = c_ST_RUN;
            default:    w_state_next = c_ST_RUN;
        endcase
    end

    // Run length saturates just past the limit; only "exceeded" matters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_run <= '0;
            r_stall_err <= 1'b0;
        end else if (w_stall_q) begin
            if (r_stall_run <= c_RUN_MAX) begin
                r_stall_run <= r_stall_run + 1'b1;
            end
            if (r_stall_run >= c_RUN_MAX) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_stall_run <= '0;
        end
    end

    assign w_flush_enter = (w_state_next == c_ST_FLUSH) && (r_state != c_ST_FLUSH);

`ifdef HAZARD_PERF_CNT_EN
    perf_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_en    (w_stall_q),
        .o_count (stall_cnt)
    );

    perf_counter #(
        .WIDTH (32)
    ) u_flush_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_en    (w_flush_enter),
        .o_count (flush_cnt)
    );
`else
    logic w_unused_flush_enter;
    assign w_unused_flush_enter = w_flush_enter;
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

    assign pc_id     = r_pc_id;
    assign instr_id  = r_instr_id;
    assign valid_id  = r_valid_id;
    assign state_o   = r_state;
    assign stall_err = r_stall_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed and randomized self-checking bench for
//                pipe_hazard_ctrl against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bb_data = 1'b0;
    logic        jump_taken_id = 1'b0;
    logic [31:0] pc_if = 32'h0;
    logic [31:0] instr_if = 32'h0;
    logic        pc_write_en;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        bubble_ex;
    logic [1:0]  state_o;
    logic        stall_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the IF/ID slot and controller observables.
    logic        m_known = 1'b0;
    logic [31:0] m_pc_id, m_instr_id;
    logic        m_valid, m_err;
    int          m_state, m_consec;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bb_data       (bb_data),
        .jump_taken_id (jump_taken_id),
        .pc_if         (pc_if),
        .instr_if      (instr_if),
        .pc_write_en   (pc_write_en),
        .pc_id         (pc_id),
        .instr_id      (instr_id),
        .valid_id      (valid_id),
        .bubble_ex     (bubble_ex),
        .state_o       (state_o),
        .stall_err     (stall_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_edge(input logic r, b, j, input logic [31:0] pc, ins);
        logic sq;
        int   nxt;
        if (!r) begin
            m_pc_id = 0; m_instr_id = 0; m_valid = 0; m_state = 0;
            m_consec = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
            m_known = 1'b1;
            return;
        end
        sq  = b & m_valid;
        nxt = sq ? 1 : ((m_state == 0 && j) ? 2 : 0);
        if (nxt == 2 && m_state != 2) m_flush_cnt++;
        if (sq) m_stall_cnt++;
        m_consec = sq ? m_consec + 1 : 0;
        if (m_consec > 2) m_err = 1'b1;
        m_state = nxt;
        if (!sq) begin
            m_pc_id    = pc;
            m_instr_id = j ? 32'h0 : ins;
            m_valid    = ~j;
        end
    endtask

    task automatic step(input logic r, b, j, input logic [31:0] pc, ins);
        @(negedge clk);
        rst_n = r; bb_data = b; jump_taken_id = j; pc_if = pc; instr_if = ins;
        #1;
        if (m_known) begin
            chk("pc_write_en", {31'b0, pc_write_en}, {31'b0, ~(b & m_valid)});
            chk("bubble_ex",   {31'b0, bubble_ex},   {31'b0, b & m_valid});
        end
        @(posedge clk);
        model_edge(r, b, j, pc, ins);
        #1;
        chk("pc_id",     pc_id,                m_pc_id);
        chk("instr_id",  instr_id,             m_instr_id);
        chk("valid_id",  {31'b0, valid_id},    {31'b0, m_valid});
        chk("state_o",   {30'b0, state_o},     m_state);
        chk("stall_err", {31'b0, stall_err},   {31'b0, m_err});
        chk("stall_cnt", stall_cnt,            perf(m_stall_cnt));
        chk("flush_cnt", flush_cnt,            perf(m_flush_cnt));
    endtask

    initial begin
        // Reset held with a pending stall request and a live instruction.
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h2402_0005);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h2402_0005);
        chk("rst_valid", {31'b0, valid_id}, 32'd0);
        chk("rst_instr", instr_id, 32'h0);
        chk("rst_state", {30'b0, state_o}, 32'd0);
        chk("rst_pwe",   {31'b0, pc_write_en}, 32'd1);

        // Single stall.
        step(1'b1, 1'b0, 1'b0, 32'h400, 32'h8c01_0000);
        chk("load_pc", pc_id, 32'h400);
        step(1'b1, 1'b1, 1'b0, 32'h404, 32'h8c02_0004);
        chk("stall_hold_pc", pc_id, 32'h400);
        chk("stall_state",   {30'b0, state_o}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h404, 32'h8c02_0004);
        chk("stall_exit", {30'b0, state_o}, 32'd0);
        chk("stall_cnt1", stall_cnt, perf(32'd1));

        // Flush.
        step(1'b1, 1'b0, 1'b1, 32'h408, 32'h0800_0100);
        chk("flush_pc",    pc_id, 32'h408);
        chk("flush_instr", instr_id, 32'h0);
        chk("flush_valid", {31'b0, valid_id}, 32'd0);
        chk("flush_state", {30'b0, state_o}, 32'd2);
        chk("flush_cnt1",  flush_cnt, perf(32'd1));
        step(1'b1, 1'b0, 1'b0, 32'h40c, 32'h2003_0001);
        chk("flush_exit", {30'b0, state_o}, 32'd0);

        // Stall beats jump; this also begins the watchdog run.
        step(1'b1, 1'b1, 1'b1, 32'h500, 32'h0);
        chk("prio_state", {30'b0, state_o}, 32'd1);
        chk("prio_fcnt",  flush_cnt, perf(32'd1));
        chk("prio_pc",    pc_id, 32'h40c);
        step(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
        chk("wd_not_yet", {31'b0, stall_err}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
        chk("wd_set", {31'b0, stall_err}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h504, 32'h1234_5678);
        step(1'b1, 1'b0, 1'b0, 32'h508, 32'h1234_567c);
        chk("wd_sticky", {31'b0, stall_err}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h50c, 32'h0);
        chk("wd_cleared", {31'b0, stall_err}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) >= 3),
                 ($urandom_range(99) < 40),
                 ($urandom_range(99) < 20),
                 $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
